// File: rtl/stopwatch_lap.sv
// -----------------------------------------------------------------------------
// stopwatch_lap
//   Start/stop/clear stopwatch counting BCD hh:mm:ss.cc, with a lap FIFO.
//   One key starts and stops the watch; holding it clears the time and the laps.
//   A lap press while running records the current time into a small FIFO.
//
// Parameters
//   TICK_DIV    clock cycles per 0.01 s tick (>= 2)
//   HOLD_CYCLES consecutive high cycles of i_key that trigger a clear (>= 2)
//   LAP_DEPTH   lap FIFO entries (power of two, 2..64)
//
// Ports
//   i_clk       single clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_key       start/stop/clear button (synchronous, debounced level)
//   i_lap       lap button (synchronous level)
//   i_rd        pop the lap FIFO head
//   o_time      BCD time, [31:28] hour tens .. [3:0] hundredths
//   o_run       high while running
//   o_lap       BCD time at the FIFO head (valid when o_lap_valid)
//   o_lap_valid FIFO not empty
//   o_lap_full  FIFO holds LAP_DEPTH entries
//   o_lap_ovf   sticky: a lap was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module stopwatch_lap #(
  parameter int TICK_DIV    = 500000,
  parameter int HOLD_CYCLES = 100000000,
  parameter int LAP_DEPTH   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_key,
  input  logic        i_lap,
  input  logic        i_rd,
  output logic [31:0] o_time,
  output logic        o_run,
  output logic [31:0] o_lap,
  output logic        o_lap_valid,
  output logic        o_lap_full,
  output logic        o_lap_ovf
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int AW = $clog2(LAP_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STOP, CLEAR} state_t;

  state_t        state_q, state_d;
  logic          key_q, lap_q;
  logic          key_edge, lap_edge, hold_hit, tick;
  logic          push, pop, push_ok, full;
  logic [PW-1:0] presc_q;
  logic [HW-1:0] hold_q;
  logic [31:0]   time_q;
  logic [31:0]   mem [LAP_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          ovf_q;

  // Add 0.01 s to a BCD time. Tens of seconds and minutes wrap after 5, every
  // other digit after 9; a carry out of the hour tens is dropped (99h -> 00h).
  function automatic logic [31:0] bcd_inc(input logic [31:0] t);
    logic [31:0] r;
    logic        carry;
    logic [3:0]  d, lim;
    r     = t;
    carry = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d   = t[4*i +: 4];
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (carry) begin
        if (d == lim) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign key_edge = i_key & ~key_q;
  assign lap_edge = i_lap & ~lap_q;
  // hold_q counts the high cycles before this one, so this is the
  // HOLD_CYCLES-th consecutive high cycle; saturation keeps it from re-firing.
  assign hold_hit = i_key && (hold_q == HW'(HOLD_CYCLES - 1));
  assign tick     = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));

  assign full     = (count == (AW+1)'(LAP_DEPTH));
  assign pop      = i_rd && (count != '0);
  assign push     = lap_edge && (state_q == RUN);
  // When full, a push only fits if the head leaves in the same cycle.
  assign push_ok  = push && (!full || pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: next-state gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (key_edge) state_d = RUN;
      RUN:   if (key_edge) state_d = STOP;
             else if (hold_hit) state_d = CLEAR;
      STOP:  if (key_edge) state_d = RUN;
             else if (hold_hit) state_d = CLEAR;
      CLEAR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Edge samples and hold counter. A key held through CLEAR produces no new
  // edge until it has been seen low, so no extra re-arm flag is needed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      key_q  <= 1'b0;
      lap_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      key_q <= i_key;
      lap_q <= i_lap;
      if (!i_key)                          hold_q <= '0;
      else if (hold_q != HW'(HOLD_CYCLES)) hold_q <= hold_q + HW'(1);
    end
  end

  // Prescaler and time. STOP leaves both untouched so a partial tick survives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q <= '0;
      time_q  <= '0;
    end else begin
      case (state_q)
        IDLE: presc_q <= '0;
        RUN: begin
          presc_q <= tick ? '0 : presc_q + PW'(1);
          if (tick) time_q <= bcd_inc(time_q);
        end
        CLEAR: begin
          presc_q <= '0;
          time_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Lap FIFO control.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else if (state_q == CLEAR) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (push && !push_ok) ovf_q <= 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

  // NOTE: lap storage has no reset; entries are only visible through the
  // registered count, so clearing the array would buy nothing.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= time_q;
  end

  assign o_time      = time_q;
  assign o_run       = (state_q == RUN);
  assign o_lap       = mem[rd_ptr];
  assign o_lap_valid = (count != '0);
  assign o_lap_full  = full;
  assign o_lap_ovf   = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_lap
//   Self-checking bench for stopwatch_lap (TICK_DIV=4, HOLD_CYCLES=16,
//   LAP_DEPTH=4). A reference model keeps time as a plain count of hundredths
//   and the laps in a queue; every clock cycle the DUT outputs are compared
//   against it. Table vectors and hand sequences add fixed expectations.
// -----------------------------------------------------------------------------
module tb_stopwatch_lap;

  localparam int TICK_DIV    = 4;
  localparam int HOLD_CYCLES = 16;
  localparam int LAP_DEPTH   = 4;
  localparam int CS_WRAP     = 100 * 60 * 60 * 100;  // 100 hours in hundredths

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key = 1'b0, lap = 1'b0, rd = 1'b0;
  logic [31:0] time_o, lap_o;
  logic        run_o, lap_valid_o, lap_full_o, lap_ovf_o;

  int tests = 0;
  int fails = 0;

  stopwatch_lap #(
    .TICK_DIV   (TICK_DIV),
    .HOLD_CYCLES(HOLD_CYCLES),
    .LAP_DEPTH  (LAP_DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_key      (key),
    .i_lap      (lap),
    .i_rd       (rd),
    .o_time     (time_o),
    .o_run      (run_o),
    .o_lap      (lap_o),
    .o_lap_valid(lap_valid_o),
    .o_lap_full (lap_full_o),
    .o_lap_ovf  (lap_ovf_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_STOP, M_CLEAR} mode_t;

  mode_t       m_mode;
  int          m_cs;        // elapsed hundredths
  int          m_phase;     // clock cycles into the current hundredth
  int          m_high;      // consecutive cycles key has been high
  bit          m_key_prev, m_lap_prev, m_ovf;
  logic [31:0] m_q[$];

  function automatic logic [31:0] cs_to_bcd(input int cs);
    int hh, mi, ss, cc;
    hh = cs / 360000;
    mi = (cs / 6000) % 60;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(hh / 10), 4'(hh % 10), 4'(mi / 10), 4'(mi % 10),
            4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic m_reset();
    m_mode = M_IDLE; m_cs = 0; m_phase = 0; m_high = 0;
    m_key_prev = 0; m_lap_prev = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic m_step();
    bit kedge, ledge, hold_trig, tick, pop, push;
    int sz;
    kedge     = key && !m_key_prev;
    ledge     = lap && !m_lap_prev;
    m_high    = key ? m_high + 1 : 0;
    hold_trig = (m_high == HOLD_CYCLES);
    tick      = (m_mode == M_RUN) && (m_phase == TICK_DIV - 1);
    pop       = rd && (m_q.size() > 0);
    push      = ledge && (m_mode == M_RUN);
    if (m_mode == M_CLEAR) begin
      m_q.delete();
      m_ovf = 0;
    end else begin
      sz = m_q.size();
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (sz == LAP_DEPTH && !pop) m_ovf = 1;
        else                         m_q.push_back(cs_to_bcd(m_cs));
      end
    end
    case (m_mode)
      M_IDLE: begin
        m_phase = 0;
        if (kedge) m_mode = M_RUN;
      end
      M_RUN: begin
        m_phase = (m_phase + 1) % TICK_DIV;
        if (tick) m_cs = (m_cs + 1) % CS_WRAP;
        if (kedge)          m_mode = M_STOP;
        else if (hold_trig) m_mode = M_CLEAR;
      end
      M_STOP: begin
        if (kedge)          m_mode = M_RUN;
        else if (hold_trig) m_mode = M_CLEAR;
      end
      default: begin
        m_cs = 0; m_phase = 0; m_mode = M_IDLE;
      end
    endcase
    m_key_prev = key;
    m_lap_prev = lap;
  endtask

  task automatic compare_model();
    check("model run",   32'(run_o),       32'(m_mode == M_RUN));
    check("model time",  time_o,           cs_to_bcd(m_cs));
    check("model valid", 32'(lap_valid_o), 32'(m_q.size() > 0));
    check("model full",  32'(lap_full_o),  32'(m_q.size() == LAP_DEPTH));
    check("model ovf",   32'(lap_ovf_o),   32'(m_ovf));
    if (m_q.size() > 0) check("model lap head", lap_o, m_q[0]);
  endtask

  // One clock: DUT and model both see the inputs held across the edge,
  // outputs are compared 1 ns later.
  task automatic cycle();
    @(posedge clk);
    m_step();
    #1;
    compare_model();
  endtask

  task automatic lap_pulse();
    lap = 1'b1; cycle();
    lap = 1'b0; repeat (4) cycle();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    int          n;
    logic        key, lap, rd;
    logic        exp_run;
    logic [31:0] exp_time;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] exp_laps [5];
  logic [31:0] exp_second, exp_new;

  initial begin
    vecs[0] = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000};  // start
    vecs[1] = '{40, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010};  // 10 ticks
    vecs[2] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010};  // stop, prescaler at 1
    vecs[3] = '{20, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010};  // frozen
    vecs[4] = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0010};  // resume
    vecs[5] = '{2,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010};  // prescaler 3
    vecs[6] = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0011};  // partial tick completes
    vecs[7] = '{4,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0012};

    // reset state
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset time",  time_o,           32'h0);
    check("reset run",   32'(run_o),       32'h0);
    check("reset valid", 32'(lap_valid_o), 32'h0);
    check("reset full",  32'(lap_full_o),  32'h0);
    check("reset ovf",   32'(lap_ovf_o),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // start / stop / resume timing
    for (int i = 0; i < 8; i++) begin
      key = vecs[i].key; lap = vecs[i].lap; rd = vecs[i].rd;
      for (int c = 0; c < vecs[i].n; c++) cycle();
      check($sformatf("vec%0d run", i),  32'(run_o), 32'(vecs[i].exp_run));
      check($sformatf("vec%0d time", i), time_o,     vecs[i].exp_time);
    end
    key = 1'b0;

    // full FIFO with simultaneous push and pop
    for (int j = 0; j < 4; j++) lap_pulse();
    check("fill full", 32'(lap_full_o), 32'h1);
    check("fill ovf",  32'(lap_ovf_o),  32'h0);
    exp_second = m_q[1];
    exp_new    = cs_to_bcd(m_cs);
    lap = 1'b1; rd = 1'b1; cycle();
    lap = 1'b0; rd = 1'b0;
    check("pushpop full", 32'(lap_full_o), 32'h1);
    check("pushpop ovf",  32'(lap_ovf_o),  32'h0);
    check("pushpop head", lap_o,           exp_second);
    rd = 1'b1; repeat (3) cycle();
    rd = 1'b0;
    check("pushpop tail", lap_o, exp_new);
    rd = 1'b1; cycle();
    rd = 1'b0;
    check("drain valid", 32'(lap_valid_o), 32'h0);

    // five laps into four entries
    for (int j = 0; j < 5; j++) begin
      exp_laps[j] = cs_to_bcd(m_cs);
      lap_pulse();
    end
    check("ovf full", 32'(lap_full_o), 32'h1);
    check("ovf flag", 32'(lap_ovf_o),  32'h1);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("lap order %0d", j), lap_o, exp_laps[j]);
      rd = 1'b1; cycle();
      rd = 1'b0;
    end
    check("laps drained", 32'(lap_valid_o), 32'h0);
    rd = 1'b1; cycle();
    rd = 1'b0;
    check("empty read valid", 32'(lap_valid_o), 32'h0);
    check("empty read full",  32'(lap_full_o),  32'h0);

    // hold to clear, starting from STOP
    lap_pulse();
    key = 1'b1; cycle();
    key = 1'b0; cycle();
    check("pre-hold stop", 32'(run_o), 32'h0);
    key = 1'b1; cycle();
    check("hold toggles run", 32'(run_o), 32'h1);
    repeat (14) cycle();
    check("hold 15 still run", 32'(run_o), 32'h1);
    cycle();
    check("clear run", 32'(run_o), 32'h0);
    cycle();
    check("after clear time",  time_o,           32'h0);
    check("after clear valid", 32'(lap_valid_o), 32'h0);
    check("after clear ovf",   32'(lap_ovf_o),   32'h0);
    repeat (20) cycle();
    check("held idle run", 32'(run_o), 32'h0);
    key = 1'b0; cycle();
    key = 1'b1; cycle();
    check("restart run", 32'(run_o), 32'h1);
    key = 1'b0; repeat (6) cycle();

    // wrap from 99:59:59.99: stop, load time_q directly, resume
    key = 1'b1; cycle();
    key = 1'b0; cycle();
    force dut.time_q = 32'h9959_5999;
    #1;
    release dut.time_q;
    m_cs = CS_WRAP - 1;
    check("preload time", time_o, 32'h9959_5999);
    key = 1'b1; cycle();
    key = 1'b0; repeat (4) cycle();
    check("wrap time", time_o,     32'h0);
    check("wrap run",  32'(run_o), 32'h1);

    // asynchronous reset between edges with time and laps present
    repeat (8) cycle();
    for (int j = 0; j < 5; j++) lap_pulse();
    #3;
    rst_n = 1'b0;
    #1;
    check("async time",  time_o,           32'h0);
    check("async run",   32'(run_o),       32'h0);
    check("async valid", 32'(lap_valid_o), 32'h0);
    check("async full",  32'(lap_full_o),  32'h0);
    check("async ovf",   32'(lap_ovf_o),   32'h0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // random stimulus against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) key = ~key;
      lap = ($urandom_range(0, 2) == 0);
      rd  = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap.md
STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000, meaning clock cycles per 0.01 s tick (minimum 2).
REQ-002 SHALL have parameter HOLD_CYCLES, default 100000000, meaning consecutive high cycles of i_key that trigger clear (minimum 2).
REQ-003 SHALL have parameter LAP_DEPTH, default 8, meaning lap FIFO entries (power of two, 2..64).
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port i_key, input, 1 bit: start/stop/clear button, synchronous and debounced level.
REQ-007 SHALL have port i_lap, input, 1 bit: lap button, synchronous level.
REQ-008 SHALL have port i_rd, input, 1 bit: pop the lap FIFO head.
REQ-009 SHALL have port o_time, output, 32 bits: BCD hh:mm:ss.cc, [31:28]=hr tens down to [3:0]=hundredths.
REQ-010 SHALL have port o_run, output, 1 bit: high while in RUN.
REQ-011 SHALL have port o_lap, output, 32 bits: BCD time at the FIFO head, valid when o_lap_valid is high.
REQ-012 SHALL have port o_lap_valid, output, 1 bit: FIFO not empty.
REQ-013 SHALL have port o_lap_full, output, 1 bit: FIFO holds LAP_DEPTH entries.
REQ-014 SHALL have port o_lap_ovf, output, 1 bit: sticky flag, a lap was dropped.

Function
REQ-015 SHALL detect a rising edge of i_key and of i_lap as input high in the current cycle and low in the previous registered sample; actions take effect at the next clock edge.
REQ-016 SHALL implement states IDLE, RUN, STOP and CLEAR.
REQ-017 IDLE: key edge -> RUN; prescaler zeroed on entry to RUN from IDLE.
REQ-018 RUN: key edge -> STOP; prescaler counts 0..TICK_DIV-1; time advances by 0.01 s in the cycle the prescaler equals TICK_DIV-1.
REQ-019 STOP: key edge -> RUN; time and prescaler hold their values (a partial tick is preserved).
REQ-020 In RUN or STOP, i_key high for HOLD_CYCLES consecutive cycles -> CLEAR; the edge that started the hold has already toggled RUN/STOP.
REQ-021 CLEAR lasts one cycle: time zeroed, FIFO flushed, o_lap_ovf cleared; next state IDLE.
REQ-022 After CLEAR, further key edges are ignored until i_key has been observed low for at least one cycle.
REQ-023 A hold in IDLE SHALL NOT trigger CLEAR; the hold counter resets whenever i_key is low and saturates at HOLD_CYCLES.
REQ-024 Time digits SHALL roll over: cc 99->00 carries to ss, ss 59->00 carries to mm, mm 59->00 carries to hh, and hh 99->00 wraps to 00:00:00.00 with counting continuing.
REQ-025 A lap edge in RUN pushes the current o_time value (before the same-cycle tick increment) into the FIFO; lap edges in IDLE, STOP and CLEAR are ignored.
REQ-026 A push when the FIFO is full and no pop occurs in the same cycle SHALL be dropped, leave contents unchanged, and set o_lap_ovf.
REQ-027 i_rd with o_lap_valid high pops the head at the next edge; i_rd while the FIFO is empty is ignored.
REQ-028 A simultaneous push and pop SHALL both take effect with the count unchanged, including when the FIFO is full.
REQ-029 o_lap SHALL present the head combinationally from FIFO storage; o_lap_full and o_lap_valid are derived from a registered count of width clog2(LAP_DEPTH)+1.

Reset
REQ-030 i_rst_n low SHALL asynchronously force state IDLE, o_time 0, prescaler 0, hold counter 0, FIFO empty, o_run 0, o_lap_valid 0, o_lap_full 0, o_lap_ovf 0 and edge-sample registers 0; o_lap is don't-care.
REQ-031 Reset deassertion SHALL be used synchronously; mid-run reset loses all time and lap data.

Verification (TICK_DIV=4, HOLD_CYCLES=16, LAP_DEPTH=4)
REQ-032 Key pulse 1 cycle, wait 40 cycles -> o_run=1 and o_time=0x00000010; key pulse -> o_run=0, time frozen for 20 cycles; key pulse -> counting resumes from the preserved prescaler.
REQ-033 Preload to 99:59:59.99 via run -> after the next tick o_time=0x00000000 and o_run remains 1.
REQ-034 5 lap edges in RUN at distinct times with no reads -> o_lap_full=1, o_lap_ovf=1, and 4 reads return the first 4 times in order, then o_lap_valid=0.
REQ-035 FIFO full, lap edge and i_rd in the same cycle -> count stays 4, oldest entry gone, newest entry at the tail, o_lap_ovf unchanged.
REQ-036 In STOP, hold i_key 16 cycles -> CLEAR one cycle, then IDLE with o_time=0, FIFO empty, o_lap_ovf=0; continued hold does not start; release then press -> RUN.
REQ-037 Assert i_rst_n=0 mid-RUN between clock edges -> outputs reach their reset values immediately, without waiting for a clock edge.
